ctrl_event_queue: RTL and testbench

CTRL_EVENT_QUEUE -- requirements
Module: ctrl_event_queue

---
 rtl/ctrl_event_queue.sv | 197 +++++++++++++++++++
 tb/tb_ctrl_event_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_event_queue.sv
// ctrl_event_queue: per-channel change detector feeding a first-word-fall-through
// event FIFO. Each of three decoded control channels is compared against its
// previous value; a change snapshots {signal, timing} into a per-channel pending
// slot, and one pending slot (lowest channel first) is pushed per cycle.
// A change on a channel whose previous event is still pending and not being
// pushed overwrites it and is counted as a lost event.
// Optional feature: define CTRL_EVENT_STAMP_EN to add a 16-bit free-running
// cycle counter and an out_stamp port carrying the detecting-cycle stamp.
module ctrl_event_queue #(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    in_signal1,
  input  logic [1:0]                    in_signal2,
  input  logic [1:0]                    in_signal3,
  input  logic [11:0]                   in_timing1,
  input  logic [11:0]                   in_timing2,
  input  logic [11:0]                   in_timing3,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [15:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_count
`ifdef CTRL_EVENT_STAMP_EN
  ,
  output logic [15:0]                   out_stamp
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [1:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, a} + {{(DROP_W-1){1'b0}}, inc};
    if (sum[DROP_W]) return {DROP_W{1'b1}};
    return sum[DROP_W-1:0];
  endfunction

  logic [1:0]  sig_in [3];
  logic [11:0] tim_in [3];

  assign sig_in[0] = in_signal1;
  assign sig_in[1] = in_signal2;
  assign sig_in[2] = in_signal3;
  assign tim_in[0] = in_timing1;
  assign tim_in[1] = in_timing2;
  assign tim_in[2] = in_timing3;

  // ---- stage p0: change detection and per-channel pending snapshots ----
  logic [1:0]  prev_p0 [3];
  logic [2:0]  vld_p0;
  logic [13:0] snap_p0 [3];

  logic [2:0]  chg;
  logic [2:0]  sel_oh;
  logic [2:0]  pushed;
  logic [2:0]  drop;
  logic [1:0]  n_drop;
  logic        pop;
  logic        push;
  logic        full;
  logic [15:0] push_rec;

`ifdef CTRL_EVENT_STAMP_EN
  logic [15:0] cyc_cnt;
  logic [15:0] cyc_next;
  logic [15:0] stamp_p0 [3];
  logic [15:0] push_stamp;
  logic [15:0] stamp_mem [FIFO_DEPTH];
  assign cyc_next = cyc_cnt + 16'd1;
`endif

  // ---- stage p1: FIFO storage ----
  logic [15:0]   mem_p1 [FIFO_DEPTH];
  logic [AW-1:0] wptr_p1;
  logic [AW-1:0] rptr_p1;

  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = (|vld_p0) & (~full | pop);
  assign out_data  = out_valid ? mem_p1[rptr_p1] : 16'h0000;
`ifdef CTRL_EVENT_STAMP_EN
  assign out_stamp = out_valid ? stamp_mem[rptr_p1] : 16'h0000;
`endif

  // Change detect, lowest-channel-first selection and drop decisions
  always_comb begin
    chg      = '0;
    sel_oh   = '0;
    pushed   = '0;
    drop     = '0;
    push_rec = 16'h0000;
`ifdef CTRL_EVENT_STAMP_EN
    push_stamp = 16'h0000;
`endif
    for (int n = 0; n < 3; n++) chg[n] = (sig_in[n] != prev_p0[n]);
    if (vld_p0[0]) begin
      sel_oh   = 3'b001;
      push_rec = {2'd1, snap_p0[0]};
`ifdef CTRL_EVENT_STAMP_EN
      push_stamp = stamp_p0[0];
`endif
    end else if (vld_p0[1]) begin
      sel_oh   = 3'b010;
      push_rec = {2'd2, snap_p0[1]};
`ifdef CTRL_EVENT_STAMP_EN
      push_stamp = stamp_p0[1];
`endif
    end else if (vld_p0[2]) begin
      sel_oh   = 3'b100;
      push_rec = {2'd3, snap_p0[2]};
`ifdef CTRL_EVENT_STAMP_EN
      push_stamp = stamp_p0[2];
`endif
    end
    pushed = push ? sel_oh : 3'b000;
    drop   = chg & vld_p0 & ~pushed;
    n_drop = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
  end

  // Pending/previous-value control and lost-event accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 3; n++) prev_p0[n] <= 2'b00;
      vld_p0     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (chg[n]) begin
          prev_p0[n] <= sig_in[n];
          vld_p0[n]  <= 1'b1;
        end else if (pushed[n]) begin
          vld_p0[n]  <= 1'b0;
        end
      end
      if (|drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_add(drop_count, n_drop);
      end
    end
  end

  // Snapshot capture of the newest value on every detected change
  always_ff @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (chg[n]) begin
        snap_p0[n] <= {sig_in[n], tim_in[n]};
`ifdef CTRL_EVENT_STAMP_EN
        stamp_p0[n] <= cyc_next;
`endif
      end
    end
  end

`ifdef CTRL_EVENT_STAMP_EN
  // Free-running cycle counter; a stamp is the count of edges since reset
  always_ff @(posedge clk) begin
    if (rst) cyc_cnt <= 16'd0;
    else     cyc_cnt <= cyc_next;
  end

  // Stamp storage travelling alongside the record storage
  always_ff @(posedge clk) begin
    if (push) stamp_mem[wptr_p1] <= push_stamp;
  end
`endif

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_p1    <= '0;
      rptr_p1    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr_p1 <= wptr_p1 + 1'b1;
      if (pop)  rptr_p1 <= rptr_p1 + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO record storage
  always_ff @(posedge clk) begin
    if (push) mem_p1[wptr_p1] <= push_rec;
  end

endmodule

// File: tb/tb_ctrl_event_queue.sv
// Directed bench for ctrl_event_queue (default FIFO_DEPTH=8, DROP_W=8).
module tb_ctrl_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_signal1, in_signal2, in_signal3;
  logic [11:0] in_timing1, in_timing2, in_timing3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;
`ifdef CTRL_EVENT_STAMP_EN
  logic [15:0] out_stamp;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_event_queue #(.FIFO_DEPTH(8), .DROP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_signal1 (in_signal1),
    .in_signal2 (in_signal2),
    .in_signal3 (in_signal3),
    .in_timing1 (in_timing1),
    .in_timing2 (in_timing2),
    .in_timing3 (in_timing3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
`ifdef CTRL_EVENT_STAMP_EN
    ,
    .out_stamp  (out_stamp)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [15:0] e;
  logic [1:0]  v;

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    in_signal1 = 2'b00; in_signal2 = 2'b00; in_signal3 = 2'b00;
    in_timing1 = 12'd0; in_timing2 = 12'd0; in_timing3 = 12'd0;

    // reset state
    step(250);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'h0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;

    // single event on channel 2, two-edge latency, popped next edge
    out_ready = 1'b1;
    in_signal2 = 2'b01; in_timing2 = 12'd362;
    step();
    check_eq("t1_lat1_valid", 32'(out_valid), 32'd0);
    step();
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_data", 32'(out_data), 32'h916A);
    check_eq("t1_count", 32'(fifo_count), 32'd1);
    step();
    check_eq("t1_count_after", 32'(fifo_count), 32'd0);
    check_eq("t1_valid_after", 32'(out_valid), 32'd0);

    // simultaneous changes on all channels, delivered in channel order
    in_signal1 = 2'b10; in_signal2 = 2'b10; in_signal3 = 2'b10;
    in_timing1 = 12'd5; in_timing2 = 12'd6; in_timing3 = 12'd7;
    step(2);
    check_eq("t2_rec1", 32'(out_data), 32'h6005);
    step();
    check_eq("t2_rec2", 32'(out_data), 32'hA006);
    step();
    check_eq("t2_rec3", 32'(out_data), 32'hE007);
    step();
    check_eq("t2_empty", 32'(fifo_count), 32'd0);
    check_eq("t2_drop", 32'(drop_count), 32'd0);

    // backpressure: 9 events on ch1, FIFO holds 8, 9th stays pending
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_signal1 = (i % 2 == 0) ? 2'b01 : 2'b10;
      in_timing1 = 12'(i);
      step(2);
    end
    check_eq("t3_full_count", 32'(fifo_count), 32'd8);
    check_eq("t3_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      v = (j % 2 == 0) ? 2'b01 : 2'b10;
      e = {2'b01, v, 12'(j)};
      check_eq($sformatf("t3_rec%0d", j), {15'd0, out_valid, out_data}, {15'd0, 1'b1, e});
      step();
    end
    check_eq("t3_drained", 32'(fifo_count), 32'd0);

    // FIFO full, ch3 toggles three times: two drops, newest delivered
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_signal2 = (i % 2 == 0) ? 2'b01 : 2'b10;
      in_timing2 = 12'(200 + i);
      step(2);
    end
    check_eq("t4_full", 32'(fifo_count), 32'd8);
    for (int t = 0; t < 3; t++) begin
      in_signal3 = (t % 2 == 0) ? 2'b01 : 2'b10;
      in_timing3 = 12'(100 + t);
      step(2);
    end
    check_eq("t4_drop", 32'(drop_count), 32'd2);
    check_eq("t4_ovf", 32'(overflow), 32'd1);
    check_eq("t4_count", 32'(fifo_count), 32'd8);
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      v = (j % 2 == 0) ? 2'b01 : 2'b10;
      e = {2'b10, v, 12'(200 + j)};
      check_eq($sformatf("t4_rec%0d", j), 32'(out_data), 32'(e));
      step();
    end
    check_eq("t4_ch3_newest", 32'(out_data), 32'hD066);
    step();
    check_eq("t4_drained", 32'(fifo_count), 32'd0);

    // reset with 4 queued and 1 pending, then re-detection of held inputs
    out_ready = 1'b0;
    in_signal2 = 2'b01; step(2);
    in_signal2 = 2'b10; step(2);
    in_signal1 = 2'b10; in_signal2 = 2'b01; in_signal3 = 2'b10;
    step(3);
    check_eq("t5_queued", 32'(fifo_count), 32'd4);
    rst = 1'b1;
    in_signal1 = 2'b01; in_signal2 = 2'b01; in_signal3 = 2'b01;
    in_timing1 = 12'h111; in_timing2 = 12'h222; in_timing3 = 12'h333;
    step();
    check_eq("t5_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t5_rst_count", 32'(fifo_count), 32'd0);
    check_eq("t5_rst_ovf", 32'(overflow), 32'd0);
    check_eq("t5_rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;
    step();
    check_eq("t5_detect_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    check_eq("t5_rec1", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h5111});
    step();
    check_eq("t5_rec2", 32'(out_data), 32'h9222);
    step();
    check_eq("t5_rec3", 32'(out_data), 32'hD333);
    step();
    check_eq("t5_empty", 32'(fifo_count), 32'd0);
    step();
    check_eq("t5_empty_pop_ignored", 32'(fifo_count), 32'd0);

`ifdef CTRL_EVENT_STAMP_EN
    // event detected 100 edges after reset carries stamp 100
    rst = 1'b1;
    in_signal1 = 2'b00; in_signal2 = 2'b00; in_signal3 = 2'b00;
    step();
    rst = 1'b0;
    step(99);
    in_signal1 = 2'b10; in_timing1 = 12'h0AB;
    step(2);
    check_eq("stamp_data", 32'(out_data), 32'h60AB);
    check_eq("stamp_value", 32'(out_stamp), 32'd100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
